// File: rtl/sar_adc_control.sv
// rtl/sar_adc_control.sv - successive-approximation ADC controller driving an 8-bit R2R DAC
module sar_adc_control #(
  parameter int DIV_DEFAULT = 9,
  parameter int DIV_MIN     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       comp_in,
  input  logic       load_divider,
  input  logic [7:0] data,
  output logic [7:0] dac_out,
  output logic [7:0] result,
  output logic       valid,
  output logic       busy
);

  localparam logic [7:0] C_DIV_DEFAULT = 8'(DIV_DEFAULT);
  localparam logic [7:0] C_DIV_MIN     = 8'(DIV_MIN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic       r_sync1;
  logic       r_comp_s;
  logic [7:0] r_div;
  logic [7:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_trial;
  logic [7:0] r_result;
  logic       r_valid;

  logic       w_begin;
  logic       w_resolve;
  logic       w_last_bit;
  logic       w_load_ok;
  logic [7:0] w_div_load;
  logic [7:0] w_div_first;
  logic [7:0] w_bit_mask;
  logic [7:0] w_code;

  // Divider writes are only honoured between conversions, and are clamped
  // so a bit never gets fewer cycles than the comparator path needs.
  assign w_div_load  = (data < C_DIV_MIN) ? C_DIV_MIN : data;
  assign w_load_ok   = load_divider && (r_state != SETTLE);
  // A load in the same cycle as a start already governs that conversion.
  assign w_div_first = w_load_ok ? w_div_load : r_div;

  assign w_resolve   = (r_state == SETTLE) && (r_cnt == 8'd0);
  assign w_last_bit  = (r_bit == 3'd0);
  assign w_bit_mask  = 8'd1 << r_bit;
  // Keep the trial bit when Vin >= DAC, otherwise clear it.
  assign w_code      = r_comp_s ? r_trial : (r_trial & ~w_bit_mask);

  // Two-flop synchronizer for the asynchronous comparator output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_comp_s <= 1'b0;
    end else begin
      r_sync1  <= comp_in;
      r_comp_s <= r_sync1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; start during SETTLE is deliberately not looked at
  always_comb begin
    w_state_next = r_state;
    w_begin      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SETTLE;
          w_begin      = 1'b1;
        end
      end
      SETTLE: begin
        if (w_resolve && w_last_bit) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (cont || start) begin
          w_state_next = SETTLE;
          w_begin      = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Conversion datapath: divider, settle counter, bit index, trial code, result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= C_DIV_DEFAULT;
      r_cnt    <= 8'd0;
      r_bit    <= 3'd0;
      r_trial  <= 8'd0;
      r_result <= 8'd0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_load_ok) begin
        r_div <= w_div_load;
      end
      if (w_begin) begin
        r_trial <= 8'h80;
        r_bit   <= 3'd7;
        r_cnt   <= w_div_first;
      end else if (r_state == SETTLE) begin
        if (r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
        end else if (!w_last_bit) begin
          r_trial <= w_code | (w_bit_mask >> 1);
          r_bit   <= r_bit - 3'd1;
          r_cnt   <= r_div;
        end else begin
          r_trial  <= w_code;
          r_result <= w_code;
          r_valid  <= 1'b1;
        end
      end
    end
  end

  // Outside a conversion the DAC parks on the last result
  assign dac_out = (r_state == SETTLE) ? r_trial : r_result;
  assign result  = r_result;
  assign valid   = r_valid;
  assign busy    = (r_state == SETTLE);

endmodule

// File: doc/sar_adc_control.md
SAR_ADC_CONTROL -- requirements
Module: sar_adc_control

Interface
REQ-001 Parameter DIV_DEFAULT, default 9, is the settle-divider reset value (10 clocks per bit at 10 MHz).
REQ-002 Parameter DIV_MIN, default 2, is the smallest divider value the block will use.
REQ-003 Port clk, input, 1: single clock (10 MHz nominal).
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: request one conversion.
REQ-006 Port cont, input, 1: continuous mode; when high, a new conversion begins automatically after each completion.
REQ-007 Port comp_in, input, 1: asynchronous comparator output; 1 means Vin >= V(dac_out).
REQ-008 Port load_divider, input, 1: load data into the divider register.
REQ-009 Port data, input, 8: divider load value.
REQ-010 Port dac_out, output, 8: trial code driven to the R2R DAC.
REQ-011 Port result, output, 8: last completed conversion code.
REQ-012 Port valid, output, 1: one-cycle pulse when result updates.
REQ-013 Port busy, output, 1: high while a conversion is in progress.

Function
REQ-014 comp_in SHALL pass through a 2-flop synchronizer; only the synchronized value (comp_s) is used for decisions.
REQ-015 The state machine SHALL have exactly three states: IDLE, SETTLE and DONE.
REQ-016 IDLE: start=1 SHALL enter SETTLE with dac_out=0x80, bit index=7 and cnt=div.
REQ-017 SETTLE: cnt SHALL decrement each cycle while nonzero.
REQ-018 SETTLE with cnt==0 SHALL resolve the current bit: keep it if comp_s=1, clear it if comp_s=0.
REQ-019 On resolving bits 7..1, the block SHALL set the next lower bit in dac_out and reload cnt=div.
REQ-020 On resolving bit 0, the block SHALL set result to the final code, drive valid=1 and enter DONE.
REQ-021 Each bit SHALL take exactly div+1 cycles.
REQ-022 valid SHALL be high in the cycle after the 8*(div+1)th rising edge following the edge that accepted start (default: 80).
REQ-023 DONE: valid SHALL be high for exactly this one cycle.
REQ-024 DONE: if cont=1 or start=1, the block SHALL enter SETTLE with the same init as REQ-016; otherwise it SHALL enter IDLE.
REQ-025 The continuous-mode period SHALL be 8*(div+1)+1 cycles (default: 81).
REQ-026 busy SHALL be 1 in SETTLE and 0 in IDLE and DONE.
REQ-027 start while in SETTLE SHALL be ignored; conversions never restart mid-way.
REQ-028 In IDLE and DONE, dac_out SHALL equal result, so the DAC holds the last conversion.
REQ-029 load_divider=1 in IDLE or DONE SHALL load div <= max(data, DIV_MIN) on that edge.
REQ-030 load_divider=1 in SETTLE SHALL be ignored.
REQ-031 load_divider and start in the same IDLE cycle: the new div SHALL apply to that conversion's first bit (cnt loads max(data, DIV_MIN)).
REQ-032 result SHALL hold its value until the next completion; it SHALL NOT change during a conversion.
REQ-033 The bit index SHALL be 3 bits and cnt 8 bits; neither SHALL wrap outside the ranges above.

Reset
REQ-034 rst=1 at any clock edge, including mid-conversion, SHALL force state=IDLE, dac_out=0x00, result=0x00, valid=0, busy=0, div=DIV_DEFAULT, cnt=0 and the synchronizer flops to 0.
REQ-035 rst SHALL take priority over start, cont and load_divider in the same cycle.
REQ-036 After rst deasserts, no conversion SHALL begin until start=1 is sampled.

Verification
REQ-037 Reset: hold rst 2 cycles with start=1 -> dac_out=0x00, result=0x00, valid=0, busy=0, no conversion starts.
REQ-038 Comparator model Vin=0xA5 (comp_in = dac_out<=0xA5), default div, pulse start -> dac_out sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5, 10 cycles each; valid pulses once 80 edges after start; result=0xA5; busy low in the valid cycle.
REQ-039 comp_in stuck 1 -> result=0xFF; comp_in stuck 0 -> result=0x00; dac_out holds result in IDLE afterward.
REQ-040 load_divider with data=0x00 -> div=2, valid 24 edges after start; data=0x03 -> valid 32 edges after start; load_divider during busy leaves timing unchanged.
REQ-041 start pulsed at bit 5 of a conversion -> ignored, single valid; rst asserted at bit 4 -> next cycle IDLE, all outputs 0x00/0, no valid ever emitted for the aborted conversion.
REQ-042 cont=1 with Vin=0x3C -> valid pulses every 81 cycles, result=0x3C each time; drop cont -> block returns to IDLE after the current completion.
